// File: rtl/fir_seq_param.sv
// Time-multiplexed signed FIR filter: one shared multiplier, TAPS MAC cycles per sample,
// runtime-loadable coefficients, arithmetic output scaling and saturation.
module fir_seq_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clr_hist,
  input  logic                       coef_wr,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  output logic                       sat,
  output logic                       busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  // Saturation limits, sign-extended to a width that holds both the shifted
  // accumulator and the output range.
  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_x [TAPS];
  logic signed [COEF_W-1:0]  r_c [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_valid;
  logic                      r_sat;

  logic signed [PROD_W-1:0]  w_x_ext;
  logic signed [PROD_W-1:0]  w_c_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_acc_sh;
  logic signed [CMP_W-1:0]   w_r_ext;
  logic                      w_over;
  logic                      w_under;

  // Operands are widened to the product width first so the signed multiply
  // is evaluated at full precision.
  assign w_x_ext    = {{COEF_W{r_x[r_idx][DATA_W-1]}}, r_x[r_idx]};
  assign w_c_ext    = {{DATA_W{r_c[r_idx][COEF_W-1]}}, r_c[r_idx]};
  assign w_prod     = w_x_ext * w_c_ext;
  assign w_prod_ext = {{IDX_W{w_prod[PROD_W-1]}}, w_prod};

  assign w_acc_sh = r_acc >>> SHIFT;
  assign w_r_ext  = {{(CMP_W-ACC_W){w_acc_sh[ACC_W-1]}}, w_acc_sh};
  assign w_over   = (w_r_ext > SAT_MAX);
  assign w_under  = (w_r_ext < SAT_MIN);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sat       = r_sat;

  // NOTE: every register here, state or data, is updated with <= so all reads
  // in this block see the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      // NOTE: the delay line and coefficient bank are small register arrays,
      // not RAM, so they are reset like any other state (pass-through taps).
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (coef_wr) begin
            r_c[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            r_x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              r_x[k] <= clr_hist ? '0 : r_x[k-1];
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end else if (clr_hist) begin
            for (int k = 0; k < TAPS; k++) begin
              r_x[k] <= '0;
            end
          end
        end

        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(TAPS - 1)) begin
            r_state <= S_OUT;
          end
        end

        S_OUT: begin
          if (w_over) begin
            r_out_data <= {1'b0, {(OUT_W-1){1'b1}}};
            r_sat      <= 1'b1;
          end else if (w_under) begin
            r_out_data <= {1'b1, {(OUT_W-1){1'b0}}};
            r_sat      <= 1'b1;
          end else begin
            r_out_data <= w_r_ext[OUT_W-1:0];
            r_sat      <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_param.sv
// Randomised scoreboard bench for fir_seq_param: SHIFT=0 and SHIFT=2 instances share
// stimulus; a tap-sum reference model predicts each output and its arrival edge.
module tb_fir_seq_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int OUT_W  = 16;
  localparam int IDX_W  = $clog2(TAPS);
  localparam int MAXO   = (1 << (OUT_W - 1)) - 1;
  localparam int MINO   = -(1 << (OUT_W - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n     = 1'b0;
  logic signed [DATA_W-1:0]  in_data   = '0;
  logic                      in_valid  = 1'b0;
  logic                      clr_hist  = 1'b0;
  logic                      coef_wr   = 1'b0;
  logic [IDX_W-1:0]          coef_addr = '0;
  logic signed [COEF_W-1:0]  coef_data = '0;

  logic                      d0_in_ready, d0_out_valid, d0_sat, d0_busy;
  logic signed [OUT_W-1:0]   d0_out_data;
  logic                      d2_in_ready, d2_out_valid, d2_sat, d2_busy;
  logic signed [OUT_W-1:0]   d2_out_data;

  fir_seq_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(d0_in_ready),
    .clr_hist(clr_hist), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(d0_out_data), .out_valid(d0_out_valid), .sat(d0_sat), .busy(d0_busy)
  );

  fir_seq_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(d2_in_ready),
    .clr_hist(clr_hist), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(d2_out_data), .out_valid(d2_out_valid), .sat(d2_sat), .busy(d2_busy)
  );

  typedef struct {
    int d0;
    bit s0;
    int d2;
    bit s2;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  logic rst_seen = 1'b0;

  int hist [TAPS];
  int coef [TAPS];
  int next_ok = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void scale_sat(input int acc, input int sh, output int d, output bit s);
    int r;
    r = acc >>> sh;
    if (r > MAXO) begin
      d = MAXO; s = 1'b1;
    end else if (r < MINO) begin
      d = MINO; s = 1'b1;
    end else begin
      d = r;    s = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    foreach (hist[k]) begin
      hist[k] = 0;
      coef[k] = (k == 0) ? 1 : 0;
    end
  endfunction

  // One clock of stimulus: checks the handshake state left by the previous edge,
  // drives inputs for the next edge and advances the reference model.
  task automatic cycle(input bit do_rst, input bit valid, input int data, input bit clr,
                       input bit wr, input int addr, input int cdata, output bit accepted);
    int   edge_n;
    bit   idle_exp;
    int   acc;
    exp_t e;
    exp_t keep[$];
    edge_n   = cyc + 1;
    idle_exp = (edge_n >= next_ok);
    check("in_ready s0", d0_in_ready, idle_exp);
    check("in_ready s2", d2_in_ready, idle_exp);
    check("busy s0", d0_busy, !idle_exp);
    check("busy s2", d2_busy, !idle_exp);

    rst_n     = !do_rst;
    in_valid  = valid;
    in_data   = DATA_W'(data);
    clr_hist  = clr;
    coef_wr   = wr;
    coef_addr = IDX_W'(addr);
    coef_data = COEF_W'(cdata);
    accepted  = 1'b0;

    if (do_rst) begin
      model_reset();
      foreach (q[i]) if (q[i].due < edge_n) keep.push_back(q[i]);
      q       = keep;
      next_ok = edge_n + 1;
    end else if (idle_exp) begin
      if (wr) coef[addr] = cdata;
      if (valid) begin
        accepted = 1'b1;
        if (clr) foreach (hist[k]) hist[k] = 0;
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = data;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hist[k] * coef[k];
        scale_sat(acc, 0, e.d0, e.s0);
        scale_sat(acc, 2, e.d2, e.s2);
        e.due   = edge_n + TAPS + 1;
        q.push_back(e);
        next_ok = edge_n + TAPS + 2;
      end else if (clr) begin
        foreach (hist[k]) hist[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, a);
  endtask

  task automatic drain();
    idle(TAPS + 2);
  endtask

  task automatic wrc(input int addr, input int val);
    bit a;
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, addr, val, a);
  endtask

  task automatic clr();
    bit a;
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0, a);
  endtask

  task automatic send(input int data);
    bit a;
    a = 1'b0;
    for (int t = 0; t < 4 * TAPS && !a; t++) begin
      cycle(1'b0, 1'b1, data, 1'b0, 1'b0, 0, 0, a);
    end
    if (!a) check("sample accept timeout", 0, 1);
  endtask

  // Monitor: compares each output strobe against the oldest expectation and
  // verifies that outputs hold between strobes.
  int last_d0 = 0, last_d2 = 0;
  bit last_s0 = 0, last_s2 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      check("reset out_valid s0", d0_out_valid, 0);
      check("reset out_valid s2", d2_out_valid, 0);
      check("reset out_data s0", d0_out_data, 0);
      check("reset out_data s2", d2_out_data, 0);
      check("reset sat s0", d0_sat, 0);
      check("reset sat s2", d2_sat, 0);
      last_d0 = 0; last_d2 = 0; last_s0 = 0; last_s2 = 0;
    end else if (d0_out_valid || d2_out_valid) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("out_valid missing", 0, 1);
        void'(q.pop_front());
      end
      if (q.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_valid s0", d0_out_valid, 1);
        check("out_valid s2", d2_out_valid, 1);
        check("output edge", cyc, e.due);
        check("out_data s0", d0_out_data, e.d0);
        check("sat s0", d0_sat, e.s0);
        check("out_data s2", d2_out_data, e.d2);
        check("sat s2", d2_sat, e.s2);
        last_d0 = e.d0; last_s0 = e.s0; last_d2 = e.d2; last_s2 = e.s2;
      end
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        check("out_valid missing", 0, 1);
        void'(q.pop_front());
      end
      check("hold out_data s0", d0_out_data, last_d0);
      check("hold sat s0", d0_sat, last_s0);
      check("hold out_data s2", d2_out_data, last_d2);
      check("hold sat s2", d2_sat, last_s2);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    model_reset();
    @(posedge clk);
    #1;
    repeat (2) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, a);

    // Pass-through from reset coefficients.
    send(100);
    drain();

    // Impulse response.
    wrc(0, 3); wrc(1, -2); wrc(2, 5); wrc(3, 1);
    clr();
    send(1); send(0); send(0); send(0); send(0);
    drain();

    // Saturation in both directions.
    for (int k = 0; k < TAPS; k++) wrc(k, 127);
    clr();
    repeat (TAPS) send(127);
    repeat (TAPS) send(-128);
    drain();

    // Scaling: shifted instance rounds toward -inf.
    wrc(0, 1); wrc(1, 0); wrc(2, 0); wrc(3, 0);
    send(-7);
    drain();

    // Back-to-back samples with in_valid held high.
    for (int n = 0; n < 8; n++) send(int'($urandom_range(0, 255)) - 128);
    drain();

    // Write during a computation is dropped; same-cycle write plus sample applies.
    wrc(0, 2);
    send(10);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 99, a);
    drain();
    send(11);
    drain();
    cycle(1'b0, 1'b1, 20, 1'b0, 1'b1, 1, -3, a);
    drain();
    cycle(1'b0, 1'b1, 5, 1'b1, 1'b0, 0, 0, a);
    drain();

    // Randomised mix of samples, writes and history clears.
    for (int n = 0; n < 300; n++) begin
      cycle(1'b0, ($urandom_range(0, 9) < 5), int'($urandom_range(0, 255)) - 128,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128, a);
    end
    drain();

    // Reset on the second MAC cycle aborts the sample and restores pass-through.
    wrc(0, 7);
    send(55);
    idle(1);
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, a);
    send(42);
    drain();

    check("scoreboard empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_seq_param.md
Name: fir_seq_param

Overview:
- Parametrised, time-multiplexed signed FIR filter; successor to the fixed 8-in/16-out FIR core behind the tt_um top.
- Adds runtime-loadable coefficients, a valid/ready input handshake, a one-cycle output strobe, configurable tap count and widths, output scaling, and saturation.
- Uses one shared multiplier, so it is small enough for a TinyTapeout tile. The top-level wrapper maps ui/uio pins onto these ports.

Parameters:
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- TAPS, 4: number of taps. Must be ≥2 and a power of two.
- OUT_W, 16: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- clr_hist  in  1  clears the sample delay line (honoured in IDLE only).
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  index of the tap to write.
- coef_data  in  COEF_W  signed coefficient value.
- out_data  out  OUT_W  signed filter result; holds its value between strobes.
- out_valid  out  1  one-cycle strobe: out_data has just been updated.
- sat  out  1  saturation occurred for the current out_data. Valid with out_valid and held with out_data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - FSM goes to IDLE; delay line x[0..TAPS-1] is cleared to 0.
  - Coefficients reset to c[0]=1, all others 0 (pass-through).
  - out_data=0, out_valid=0, sat=0, busy=0, in_ready=1 on the cycle after reset.
  - Reset mid-operation aborts the computation; no out_valid is produced for the aborted sample.
- Internal widths:
  - Accumulator ACC_W = DATA_W+COEF_W+clog2(TAPS); it never wraps.
  - Each product is full-width signed DATA_W+COEF_W, sign-extended into the accumulator.
- FSM states IDLE → MAC → OUT → IDLE.
- IDLE:
  - in_ready=1, busy=0.
  - If in_valid: shift the delay line (x[k]←x[k-1], x[0]←in_data), clear the accumulator, set tap index i=0, go to MAC.
  - If clr_hist=1 without in_valid: zero the delay line and stay in IDLE.
  - If clr_hist=1 and in_valid together: zero x[1..TAPS-1], set x[0]←in_data, then proceed as an accepted sample.
- MAC:
  - Lasts exactly TAPS cycles; each cycle acc ← acc + x[i]*c[i], then i ← i+1.
  - After the i=TAPS-1 cycle, go to OUT.
  - in_ready=0. in_valid is ignored; the source must hold the sample until in_ready.
- OUT (one cycle):
  - r = acc >>> SHIFT (arithmetic shift).
  - If r > 2^(OUT_W-1)-1: out_data ← max positive, sat←1. If r < -2^(OUT_W-1): out_data ← min negative, sat←1. Otherwise out_data ← r[OUT_W-1:0], sat←0.
  - out_valid is high during the cycle after the OUT edge, i.e. while the FSM is back in IDLE. It is low at all other times.
  - Go to IDLE. in_ready=0 during OUT.
- Timing:
  - Sample accepted at edge T → out_data/out_valid visible after edge T+TAPS+1.
  - Next sample can be accepted at edge T+TAPS+2, so throughput is one sample per TAPS+2 cycles.
  - Accepting a new sample in the same cycle out_valid is high is legal.
- Coefficient writes:
  - When coef_wr=1 and busy=0: c[coef_addr] ← coef_data at the edge.
  - When coef_wr=1 and busy=1: the write is dropped silently; coefficients never change during a computation.
  - A write and an accepted sample in the same IDLE cycle are both performed; the new coefficient applies to that sample.
- Coefficients and history persist indefinitely, changing only by reset, writes or clr_hist.

Test Plan:
- Reset pass-through:
  - Release reset, drive in_data=100 with in_valid for one cycle.
  - Required: out_valid exactly TAPS+1=5 edges later, out_data=100, sat=0, in_ready low for 5 cycles.
- Impulse response:
  - Load c=[3,-2,5,1], clr_hist, then feed samples 1,0,0,0,0.
  - Required: outputs 3,-2,5,1,0 in order.
- Saturation both ways:
  - c all 127, four samples of 127: acc 64516 → out_data=32767, sat=1.
  - c all 127, four samples of -128: acc -65024 → out_data=-32768, sat=1.
- SHIFT=2 build:
  - c=[1,0,0,0], input -7.
  - Required: out_data=-2 (arithmetic shift rounds toward -inf).
- Handshake and write rules:
  - Hold in_valid continuously: one sample accepted every 6 cycles, no duplicates or drops.
  - Issue coef_wr during MAC: write ignored, next output uses the old coefficient.
- Reset mid-operation:
  - Assert rst_n=0 for 1 cycle on the 2nd MAC cycle.
  - Required: no out_valid, out_data=0, coefficients back to pass-through, next input 42 yields 42.
